// File: rtl/cache_fill_fsm_pkg.sv
// Shared constants and state type for the L1 miss-fill state machine.
package cache_fill_fsm_pkg;

  // Byte offset bits inside one cache block at the default geometry
  // (8 words x 2 bytes = 16 bytes).
  localparam int BLOCK_OFFSET_BITS = 4;

  // Bytes per data word; word addresses step by this amount.
  localparam int WORD_BYTES = 2;

  // State encoding.
  localparam logic FSM_IDLE = 1'b0;
  localparam logic FSM_FILL = 1'b1;

  typedef enum logic {
    IDLE = FSM_IDLE,
    FILL = FSM_FILL
  } fill_state_e;

endpackage

// File: rtl/cache_fill_fsm_counter.sv
// Word counter for the fill engine: synchronous clear beats enable.
module fill_word_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] cnt
);

  // Count words; held at zero by reset or clear.
  always_ff @(posedge clk) begin
    if (!rst)     cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en)  cnt <= cnt + W'(1);
  end

endmodule

// File: rtl/cache_fill_fsm.sv
// Miss handler: fetches one cache block as sequential word reads, streams
// returned words into the data array and writes the tag on the last word.
module cache_fill_fsm
  import cache_fill_fsm_pkg::*;
#(
  parameter int DWIDTH          = 16,
  parameter int AWIDTH          = 16,
  parameter int WORDS_PER_BLOCK = 8,
  parameter int MEM_LATENCY     = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              miss_detected,
  input  logic [AWIDTH-1:0] miss_address,
  output logic              fsm_busy,
  output logic              mem_req_en,
  output logic [AWIDTH-1:0] mem_req_addr,
  input  logic              memory_data_valid,
  input  logic [DWIDTH-1:0] memory_data_in,
  output logic              write_data_array,
  output logic [AWIDTH-1:0] cache_wr_addr,
  output logic [DWIDTH-1:0] cache_wr_data,
  output logic              write_tag_array
);

  // Counters are one bit wider than the word index so "all issued"
  // (== WORDS_PER_BLOCK) is representable.
  localparam int CW       = $clog2(WORDS_PER_BLOCK) + 1;
  localparam int OFF_BITS = $clog2(WORDS_PER_BLOCK * WORD_BYTES);
  localparam int WB_SHIFT = $clog2(WORD_BYTES);

  localparam logic [CW-1:0]     WPB       = CW'(WORDS_PER_BLOCK);
  localparam logic [CW-1:0]     LAST_WORD = CW'(WORDS_PER_BLOCK - 1);
  localparam logic [AWIDTH-1:0] BASE_MASK =
    ~((AWIDTH'(1) << OFF_BITS) - AWIDTH'(1));

  // The FSM counts returned words, never cycles, so latency only needs to be
  // sane; block size must be a power of two for the offset mask to work.
  if (MEM_LATENCY < 1 || WORDS_PER_BLOCK < 2 ||
      (WORDS_PER_BLOCK & (WORDS_PER_BLOCK - 1)) != 0) begin : g_bad_cfg
    $error("cache_fill_fsm: unsupported parameter set");
  end

  fill_state_e       state;
  logic [AWIDTH-1:0] block_base;
  logic [CW-1:0]     issue_cnt;
  logic [CW-1:0]     recv_cnt;

  logic in_fill;
  logic issue_active;
  logic recv_active;
  logic last_word;

  assign in_fill      = (state == FILL);
  assign issue_active = in_fill && (issue_cnt < WPB);
  assign recv_active  = in_fill && memory_data_valid;
  assign last_word    = recv_active && (recv_cnt == LAST_WORD);

  // Both counters sit at zero whenever no fill is running, so a new fill
  // always starts from word 0.
  fill_word_counter #(.W(CW)) u_issue_cnt (
    .clk (clk),
    .rst (rst),
    .clr (!in_fill),
    .en  (issue_active),
    .cnt (issue_cnt)
  );

  fill_word_counter #(.W(CW)) u_recv_cnt (
    .clk (clk),
    .rst (rst),
    .clr (!in_fill),
    .en  (recv_active),
    .cnt (recv_cnt)
  );

  // State and block base: latch the aligned base on a miss, return to IDLE
  // on the final returned word. Misses during FILL are dropped.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      block_base <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (miss_detected) begin
            block_base <= miss_address & BASE_MASK;
            state      <= FILL;
          end
        end
        FILL: begin
          if (last_word) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Output decode. Everything is gated by FILL so IDLE (including stray
  // memory valids after an abandoned fill) drives all-zero outputs.
  assign fsm_busy         = in_fill;
  assign mem_req_en       = issue_active;
  assign mem_req_addr     = issue_active
                          ? block_base + (AWIDTH'(issue_cnt) << WB_SHIFT)
                          : '0;
  assign write_data_array = recv_active;
  assign cache_wr_addr    = recv_active
                          ? block_base + (AWIDTH'(recv_cnt) << WB_SHIFT)
                          : '0;
  assign cache_wr_data    = in_fill ? memory_data_in : '0;
  assign write_tag_array  = last_word;

endmodule

// File: tb/tb_cache_fill_fsm.sv
// Self-checking bench for cache_fill_fsm: directed scenarios plus random
// fills against a queue-based reference of the expected request/write stream.
module tb_cache_fill_fsm;

  logic        clk;
  logic        rst;
  logic        miss_detected;
  logic [15:0] miss_address;
  logic        fsm_busy;
  logic        mem_req_en;
  logic [15:0] mem_req_addr;
  logic        memory_data_valid;
  logic [15:0] memory_data_in;
  logic        write_data_array;
  logic [15:0] cache_wr_addr;
  logic [15:0] cache_wr_data;
  logic        write_tag_array;

  cache_fill_fsm dut (
    .clk               (clk),
    .rst               (rst),
    .miss_detected     (miss_detected),
    .miss_address      (miss_address),
    .fsm_busy          (fsm_busy),
    .mem_req_en        (mem_req_en),
    .mem_req_addr      (mem_req_addr),
    .memory_data_valid (memory_data_valid),
    .memory_data_in    (memory_data_in),
    .write_data_array  (write_data_array),
    .cache_wr_addr     (cache_wr_addr),
    .cache_wr_data     (cache_wr_data),
    .write_tag_array   (write_tag_array)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory return modes.
  localparam int MODE_LAT   = 0;  // fixed 4-cycle latency
  localparam int MODE_GAP   = 1;  // explicit return cycles
  localparam int MODE_RAND  = 2;  // random gaps, >=1 cycle latency
  localparam int MODE_NOISE = 3;  // random valids, no requests behind them

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int mode     = MODE_LAT;

  int gap_cyc [8] = '{5, 7, 8, 12, 13, 15, 16, 20};

  // Reference: a fill is a list of 8 request addresses and 8 write addresses.
  bit          active = 1'b0;
  int          start_cyc = 0;
  logic [15:0] exp_req [$];
  logic [15:0] exp_wr  [$];

  // Memory: issue cycles of outstanding reads.
  int pend_q [$];
  int ret_idx = 0;

  // Observed statistics per scenario.
  int          busy_cnt, req_cnt, wr_cnt, tag_cnt;
  int          tag_cyc, first_tag_cyc, first_wr_cyc, rise_cyc;
  logic [15:0] last_req_addr, last_wr_addr;
  bit          prev_busy = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clr_stats();
    busy_cnt = 0; req_cnt = 0; wr_cnt = 0; tag_cnt = 0;
    tag_cyc = -1; first_tag_cyc = -1; first_wr_cyc = -1; rise_cyc = -1;
    last_req_addr = '0; last_wr_addr = '0;
  endtask

  task automatic start_fill(input logic [15:0] addr);
    logic [15:0] base;
    base = (addr / 16) * 16;
    exp_req.delete();
    exp_wr.delete();
    for (int i = 0; i < 8; i++) begin
      exp_req.push_back(base + 16'(2 * i));
      exp_wr.push_back(base + 16'(2 * i));
    end
    active    = 1'b1;
    start_cyc = cyc;
    pend_q.delete();
    ret_idx   = 0;
  endtask

  // One clock cycle: drive inputs after the falling edge, check outputs,
  // then advance the reference across the rising edge.
  task automatic tick(input logic miss, input logic [15:0] maddr, input logic r);
    logic        v, e_req, e_wr, e_tag;
    logic [15:0] d, e_req_addr, e_wr_addr;
    v = 1'b0;
    d = '0;
    case (mode)
      MODE_LAT:  if (pend_q.size() > 0 && pend_q[0] <= cyc - 4) v = 1'b1;
      MODE_GAP:  for (int k = 0; k < 8; k++)
                   if (cyc - start_cyc == gap_cyc[k] && pend_q.size() > 0) v = 1'b1;
      MODE_RAND: if (pend_q.size() > 0 && pend_q[0] <= cyc - 1) v = 1'($urandom_range(0, 1));
      default:   v = 1'($urandom_range(0, 1));
    endcase
    if (v) begin
      d = (mode == MODE_RAND || mode == MODE_NOISE) ? 16'($urandom) : 16'hA000 + 16'(ret_idx);
      ret_idx++;
      if (pend_q.size() > 0) void'(pend_q.pop_front());
    end
    miss_detected     = miss;
    miss_address      = maddr;
    rst               = r;
    memory_data_valid = v;
    memory_data_in    = d;
    #1;
    e_req      = active && exp_req.size() > 0;
    e_req_addr = e_req ? exp_req[0] : 16'h0;
    e_wr       = active && v;
    e_wr_addr  = e_wr ? exp_wr[0] : 16'h0;
    e_tag      = e_wr && exp_wr.size() == 1;
    chk("fsm_busy",         32'(fsm_busy),         32'(active));
    chk("mem_req_en",       32'(mem_req_en),       32'(e_req));
    chk("mem_req_addr",     32'(mem_req_addr),     32'(e_req_addr));
    chk("write_data_array", 32'(write_data_array), 32'(e_wr));
    chk("cache_wr_addr",    32'(cache_wr_addr),    32'(e_wr_addr));
    chk("cache_wr_data",    32'(cache_wr_data),    32'(active ? d : 16'h0));
    chk("write_tag_array",  32'(write_tag_array),  32'(e_tag));
    if (fsm_busy === 1'b1) busy_cnt++;
    if (fsm_busy === 1'b1 && !prev_busy) rise_cyc = cyc;
    prev_busy = (fsm_busy === 1'b1);
    if (mem_req_en === 1'b1) begin req_cnt++; last_req_addr = mem_req_addr; end
    if (write_data_array === 1'b1) begin
      wr_cnt++;
      last_wr_addr = cache_wr_addr;
      if (first_wr_cyc < 0) first_wr_cyc = cyc;
    end
    if (write_tag_array === 1'b1) begin
      if (tag_cnt == 0) first_tag_cyc = cyc;
      tag_cnt++;
      tag_cyc = cyc;
    end
    if (e_req) pend_q.push_back(cyc);
    @(posedge clk);
    if (!r) begin
      active = 1'b0;
      exp_req.delete();
      exp_wr.delete();
    end else if (!active) begin
      if (miss) start_fill(maddr);
    end else begin
      if (e_req) void'(exp_req.pop_front());
      if (e_wr) begin
        void'(exp_wr.pop_front());
        if (exp_wr.size() == 0) active = 1'b0;
      end
    end
    cyc++;
    @(negedge clk);
  endtask

  initial begin
    logic [15:0] ra;
    int n;
    rst = 1'b0; miss_detected = 1'b0; miss_address = '0;
    memory_data_valid = 1'b0; memory_data_in = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    clr_stats();

    // Reset state: outputs all zero under and after reset.
    repeat (3) tick(1'b0, 16'h0, 1'b0);
    repeat (2) tick(1'b0, 16'h0, 1'b1);

    // Basic fill at 0x1234 with 4-cycle memory.
    mode = MODE_LAT; clr_stats();
    tick(1'b1, 16'h1234, 1'b1);
    repeat (14) tick(1'b0, 16'h1234, 1'b1);
    chk("t1_busy_cycles", 32'(busy_cnt), 32'd12);
    chk("t1_req_cnt",     32'(req_cnt), 32'd8);
    chk("t1_wr_cnt",      32'(wr_cnt), 32'd8);
    chk("t1_first_wr",    32'(first_wr_cyc - start_cyc), 32'd5);
    chk("t1_tag_cnt",     32'(tag_cnt), 32'd1);
    chk("t1_tag_cycle",   32'(tag_cyc - start_cyc), 32'd12);
    chk("t1_last_req",    32'(last_req_addr), 32'h123E);
    chk("t1_last_wr",     32'(last_wr_addr), 32'h123E);

    // Top-of-address-space block: no carry out of the block.
    clr_stats();
    tick(1'b1, 16'hFFF7, 1'b1);
    repeat (14) tick(1'b0, 16'h0, 1'b1);
    chk("t2_last_req", 32'(last_req_addr), 32'hFFFE);
    chk("t2_last_wr",  32'(last_wr_addr), 32'hFFFE);
    chk("t2_tag_cnt",  32'(tag_cnt), 32'd1);

    // Miss held high: two fills with one idle cycle between; mid-fill
    // address pulse and the miss on the final fill cycle are ignored.
    clr_stats();
    for (int i = 0; i < 26; i++)
      tick(1'b1, (i == 5) ? 16'h5678 : 16'h2000, 1'b1);
    repeat (15) tick(1'b0, 16'h0, 1'b1);
    chk("t3_tag_cnt",  32'(tag_cnt), 32'd2);
    chk("t3_wr_cnt",   32'(wr_cnt), 32'd16);
    chk("t3_busy",     32'(busy_cnt), 32'd24);
    chk("t3_idle_gap", 32'(rise_cyc - first_tag_cyc - 1), 32'd1);
    chk("t3_last_wr",  32'(last_wr_addr), 32'h200E);

    // Irregular memory return gaps.
    mode = MODE_GAP; clr_stats();
    tick(1'b1, 16'h3456, 1'b1);
    repeat (24) tick(1'b0, 16'h0, 1'b1);
    chk("t4_tag_cycle", 32'(tag_cyc - start_cyc), 32'd20);
    chk("t4_busy",      32'(busy_cnt), 32'd20);
    chk("t4_wr_cnt",    32'(wr_cnt), 32'd8);
    chk("t4_last_wr",   32'(last_wr_addr), 32'h345E);

    // Reset at cycle 6 of a fill; late valids ignored; then a clean refill.
    mode = MODE_LAT; clr_stats();
    tick(1'b1, 16'h0800, 1'b1);
    repeat (5) tick(1'b0, 16'h0, 1'b1);
    tick(1'b0, 16'h0, 1'b0);
    clr_stats();
    repeat (8) tick(1'b0, 16'h0, 1'b1);
    chk("t5_post_rst_wr",   32'(wr_cnt), 32'd0);
    chk("t5_post_rst_req",  32'(req_cnt), 32'd0);
    chk("t5_post_rst_busy", 32'(busy_cnt), 32'd0);
    clr_stats();
    tick(1'b1, 16'h0040, 1'b1);
    repeat (14) tick(1'b0, 16'h0, 1'b1);
    chk("t5_tag_cycle", 32'(tag_cyc - start_cyc), 32'd12);
    chk("t5_wr_cnt",    32'(wr_cnt), 32'd8);
    chk("t5_last_wr",   32'(last_wr_addr), 32'h004E);

    // Idle with random valid noise.
    mode = MODE_NOISE; clr_stats();
    repeat (40) tick(1'b0, 16'($urandom), 1'b1);
    chk("t6_wr_cnt",  32'(wr_cnt), 32'd0);
    chk("t6_req_cnt", 32'(req_cnt), 32'd0);
    chk("t6_busy",    32'(busy_cnt), 32'd0);
    chk("t6_tag_cnt", 32'(tag_cnt), 32'd0);

    // Random fills with random return gaps and random mid-fill misses.
    mode = MODE_RAND;
    for (int f = 0; f < 6; f++) begin
      clr_stats();
      ra = 16'($urandom);
      tick(1'b1, ra, 1'b1);
      n = 0;
      while (active && n < 200) begin
        tick(1'($urandom_range(0, 1)), 16'($urandom), 1'b1);
        n++;
      end
      chk("t7_fill_done", 32'(active), 32'd0);
      chk("t7_wr_cnt",    32'(wr_cnt), 32'd8);
      chk("t7_tag_cnt",   32'(tag_cnt), 32'd1);
      chk("t7_last_wr",   32'(last_wr_addr), 32'((ra / 16) * 16 + 16'd14));
      repeat ($urandom_range(1, 3)) tick(1'b0, 16'h0, 1'b1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cache_fill_fsm.md
Name: cache_fill_fsm

Overview:
- Miss handler between the L1 cache arrays and the multi-cycle main memory inside memory_system.
- On a cache miss, fetches the whole 16-byte block as 8 sequential word reads, streams each returned word into the cache data array, then writes the tag.
- Its fsm_busy output drives cache_miss_stall for the pipeline.

Parameters:
- DWIDTH, 16, data word width in bits.
- AWIDTH, 16, byte address width in bits.
- WORDS_PER_BLOCK, 8, words per cache block; must be a power of two.
- MEM_LATENCY, 4, main-memory read latency in cycles; informative only. The FSM counts returned words and never counts cycles.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  synchronous, active-low reset; sampled on the rising edge of clk.
- miss_detected  input  1  cache lookup missed this cycle.
- miss_address  input  AWIDTH  byte address of the missing access.
- fsm_busy  output  1  fill in progress; drives cache_miss_stall.
- mem_req_en  output  1  issue one read to main memory this cycle.
- mem_req_addr  output  AWIDTH  byte address of the read being issued.
- memory_data_valid  input  1  main memory returns one word this cycle.
- memory_data_in  input  DWIDTH  returned word.
- write_data_array  output  1  write cache_wr_data into the data array this cycle.
- cache_wr_addr  output  AWIDTH  byte address of the word being written.
- cache_wr_data  output  DWIDTH  word being written; equals memory_data_in.
- write_tag_array  output  1  write the tag/valid entry for block_base this cycle.

Behaviour:
- States: IDLE, FILL.
- Registers: state, block_base[AWIDTH], issue_cnt[log2(WPB)+1], recv_cnt[log2(WPB)+1].
- Reset (rst==0 at an edge):
  - state=IDLE; all counters and block_base are 0.
  - Every output is 0 from the following cycle, including when reset lands mid-fill.
  - A fill in flight at reset is abandoned.
  - Late memory_data_valid pulses that arrive after reset, while in IDLE, are ignored.
- IDLE:
  - If miss_detected is sampled high, latch block_base = miss_address with the low log2(WPB*2) bits cleared (0xFFF0 mask at defaults).
  - Clear both counters and go to FILL.
  - memory_data_valid is ignored in IDLE.
- FILL:
  - fsm_busy=1 combinationally from state.
  - Issue phase: mem_req_en=1 while issue_cnt<WPB. mem_req_addr = block_base + 2*issue_cnt. issue_cnt increments each cycle it issues, so 8 consecutive cycles with no bubbles.
  - While issue_cnt==WPB: mem_req_en=0 and mem_req_addr=0.
  - Return phase, each cycle memory_data_valid=1:
    - write_data_array=1;
    - cache_wr_addr = block_base + 2*recv_cnt;
    - cache_wr_data = memory_data_in;
    - recv_cnt increments.
  - Issue and return overlap. Both may be active in the same cycle.
  - On the cycle recv_cnt==WPB-1 with valid high, write_tag_array=1 in the same cycle as the last data write. The next state is IDLE.
  - miss_detected is ignored throughout FILL, including the final cycle.
- Outputs outside FILL: mem_req_en, write_data_array and write_tag_array are 0; the address buses are 0.
- Timing with MEM_LATENCY=4, miss sampled at edge 0:
  - busy high cycles 1..12;
  - requests in cycles 1..8;
  - data writes in cycles 5..12;
  - tag write in cycle 12;
  - IDLE at cycle 13.
- Back-to-back misses: a miss held high through cycle 13 starts a new fill with busy high again from cycle 14. The single idle cycle is required.
- Address arithmetic is AWIDTH wide with no carry out. Base 0xFFF0 issues 0xFFF0..0xFFFE, and nothing wraps within a block.
- Out-of-order return is not supported; memory returns in issue order.
- memory_data_valid beyond WPB words in one fill cannot occur, because the FSM leaves FILL on the 8th word.

Decomposition:
- Shared package/include holds:
  - BLOCK_OFFSET_BITS = 4;
  - WORD_BYTES = 2;
  - state encoding localparams FSM_IDLE=1'b0, FSM_FILL=1'b1.
- One natural sub-module: fill_word_counter, a parameterized up-counter with clear and enable, instantiated twice for issue_cnt and recv_cnt.
- State register and output decode stay in the top module.

Test Plan:
- Miss at miss_address=0x1234, memory model with 4-cycle latency returning 0xA000+word index:
  - mem_req_addr 0x1230..0x123E in cycles 1..8;
  - write_data_array with cache_wr_addr 0x1230..0x123E and data 0xA000..0xA007 in cycles 5..12;
  - write_tag_array only in cycle 12; fsm_busy high for exactly 12 cycles.
- Miss at 0xFFF7: block_base=0xFFF0; last request 0xFFFE; no address beyond 0xFFFE.
- miss_detected held high continuously: two fills, busy low for exactly one cycle between them; a second miss_address pulse sent mid-fill has no effect.
- Memory model with irregular valid gaps (return cycles 5, 7, 8, 12, 13, 15, 16, 20): eight data writes in order; tag written at cycle 20; busy drops cycle 21.
- rst=0 at cycle 6 of a fill: all outputs 0 from cycle 7; the remaining valids are ignored; a new miss at 0x0040 then fills correctly from 0x0040.
- No miss and random memory_data_valid toggling in IDLE: no writes, no requests, fsm_busy stays 0.
